// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between the fetch stage
// (instruction reads) and the mem stage (data loads/stores). One transaction is
// in flight at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Build option: define ARB_ROUND_ROBIN_EN to break simultaneous-request ties
// round-robin; otherwise the data stage always wins ties.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] if_req_addr_i,
  output logic                  if_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] if_rsp_data_o,
  input  logic                  dm_req_valid_i,
  input  logic                  dm_req_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata_i,
  output logic                  dm_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] dm_rsp_data_o,
  output logic                  mem_req_valid_o,
  output logic                  mem_req_we_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_req_we_q, mem_req_we_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_WIDTH-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic                  if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_WIDTH-1:0] if_rsp_data_q, if_rsp_data_d;
  logic                  dm_rsp_valid_q, dm_rsp_valid_d;
  logic [DATA_WIDTH-1:0] dm_rsp_data_q, dm_rsp_data_d;
  logic                  busy_q, busy_d;

  logic any_req;
  logic tie_dm;
  logic grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
  // last_dm_q = 1 means the data stage was granted last; reset value lets fetch win the first tie.
  logic last_dm_q, last_dm_d;
  assign tie_dm = ~last_dm_q;
`else
  assign tie_dm = 1'b1;
`endif

  assign any_req  = if_req_valid_i | dm_req_valid_i;
  assign grant_dm = dm_req_valid_i & (~if_req_valid_i | tie_dm);

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; memory completions only matter in REQ and WAIT.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = REQ;
      REQ:     state_d = mem_rsp_valid_i ? RESP : WAIT;
      WAIT:    if (mem_rsp_valid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered from these.
  always_comb begin
    owner_d         = owner_q;
    mem_req_valid_d = (state_d == REQ);
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    if_rsp_valid_d  = 1'b0;
    if_rsp_data_d   = '0;
    dm_rsp_valid_d  = 1'b0;
    dm_rsp_data_d   = '0;
    busy_d          = (state_d != IDLE);
`ifdef ARB_ROUND_ROBIN_EN
    last_dm_d       = last_dm_q;
`endif

    // Grant: capture the winner's request; held unchanged until the return to IDLE.
    if (state_q == IDLE && any_req) begin
      owner_d = grant_dm ? OWN_DM : OWN_IF;
      if (grant_dm) begin
        mem_req_we_d    = dm_req_we_i;
        mem_req_addr_d  = dm_req_addr_i;
        mem_req_wdata_d = dm_req_we_i ? dm_req_wdata_i : '0;
      end else begin
        mem_req_we_d    = 1'b0;
        mem_req_addr_d  = if_req_addr_i;
        mem_req_wdata_d = '0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_d = grant_dm;
`endif
    end

    // Completion: route the memory data straight into the owner's response register.
    if (state_d == RESP) begin
      if (owner_q == OWN_IF) begin
        if_rsp_valid_d = 1'b1;
        if_rsp_data_d  = mem_rsp_data_i;
      end else if (owner_q == OWN_DM) begin
        dm_rsp_valid_d = 1'b1;
        dm_rsp_data_d  = mem_req_we_q ? '0 : mem_rsp_data_i;
      end
    end

    // Back in IDLE the memory request lines and owner are cleared.
    if (state_d == IDLE) begin
      owner_d         = OWN_NONE;
      mem_req_we_d    = 1'b0;
      mem_req_addr_d  = '0;
      mem_req_wdata_d = '0;
    end
  end

  // Output and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q         <= OWN_NONE;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      dm_rsp_valid_q  <= 1'b0;
      dm_rsp_data_q   <= '0;
      busy_q          <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q       <= 1'b1;
`endif
    end else begin
      owner_q         <= owner_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      if_rsp_valid_q  <= if_rsp_valid_d;
      if_rsp_data_q   <= if_rsp_data_d;
      dm_rsp_valid_q  <= dm_rsp_valid_d;
      dm_rsp_data_q   <= dm_rsp_data_d;
      busy_q          <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q       <= last_dm_d;
`endif
    end
  end

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_we_o    = mem_req_we_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_req_wdata_o = mem_req_wdata_q;
  assign if_rsp_valid_o  = if_rsp_valid_q;
  assign if_rsp_data_o   = if_rsp_data_q;
  assign dm_rsp_valid_o  = dm_rsp_valid_q;
  assign dm_rsp_data_o   = dm_rsp_data_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors plus a random scoreboard run for mem_arbiter.
// A behavioural memory answers each request pulse after a chosen latency.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid_i;
  logic [AW-1:0] if_req_addr_i;
  logic          if_rsp_valid_o;
  logic [DW-1:0] if_rsp_data_o;
  logic          dm_req_valid_i;
  logic          dm_req_we_i;
  logic [AW-1:0] dm_req_addr_i;
  logic [DW-1:0] dm_req_wdata_i;
  logic          dm_rsp_valid_o;
  logic [DW-1:0] dm_rsp_data_o;
  logic          mem_req_valid_o;
  logic          mem_req_we_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_wdata_o;
  logic          mem_rsp_valid_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic          busy_o;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_req_valid_i  (if_req_valid_i),
    .if_req_addr_i   (if_req_addr_i),
    .if_rsp_valid_o  (if_rsp_valid_o),
    .if_rsp_data_o   (if_rsp_data_o),
    .dm_req_valid_i  (dm_req_valid_i),
    .dm_req_we_i     (dm_req_we_i),
    .dm_req_addr_i   (dm_req_addr_i),
    .dm_req_wdata_i  (dm_req_wdata_i),
    .dm_rsp_valid_o  (dm_rsp_valid_o),
    .dm_rsp_data_o   (dm_rsp_data_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural memory ----------------
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  int  mem_lat      = 0;
  bit  mem_lat_rand = 1'b0;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  initial begin
    int          lat;
    logic [31:0] a, wd;
    logic        we;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      if (mem_req_valid_o === 1'b1) begin
        lat = mem_lat_rand ? int'($urandom_range(0, 20)) : mem_lat;
        a  = mem_req_addr_o;
        we = mem_req_we_o;
        wd = mem_req_wdata_o;
        repeat (lat) @(negedge clk);
        if (we) mem_model[a] = wd;
        mem_rsp_valid_i = 1'b1;
        // Stores return junk so a missing zeroing of dm_rsp_data_o shows up.
        mem_rsp_data_i  = we ? 32'hFFFF_FFFF : mem_peek(a);
      end
    end
  end

  // ---------------- observation helper ----------------
  int          req_cnt, busy_cnt, if_cnt, dm_cnt, both_cnt, if_at, dm_at, n_order;
  logic [31:0] req_addr, req_wdata, if_data, dm_data;
  logic        req_we;
  int          order [3];

  // Runs ncyc cycles, sampling at each negedge; drops a requester at its rsp unless hold.
  task automatic observe(input int ncyc, input bit hold);
    req_cnt = 0; busy_cnt = 0; if_cnt = 0; dm_cnt = 0; both_cnt = 0;
    if_at = -1; dm_at = -1; n_order = 0;
    req_addr = '0; req_wdata = '0; req_we = 1'b0; if_data = '0; dm_data = '0;
    for (int k = 0; k < 3; k++) order[k] = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (mem_req_valid_o) begin
        req_cnt++;
        req_addr  = mem_req_addr_o;
        req_we    = mem_req_we_o;
        req_wdata = mem_req_wdata_o;
      end
      if (busy_o) busy_cnt++;
      if (if_rsp_valid_o && dm_rsp_valid_o) both_cnt++;
      if (if_rsp_valid_o) begin
        if_cnt++; if_at = i; if_data = if_rsp_data_o;
        if (n_order < 3) begin order[n_order] = 1; n_order++; end
        if (!hold) if_req_valid_i = 1'b0;
      end
      if (dm_rsp_valid_o) begin
        dm_cnt++; dm_at = i; dm_data = dm_rsp_data_o;
        if (n_order < 3) begin order[n_order] = 2; n_order++; end
        if (!hold) dm_req_valid_i = 1'b0;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    32'(busy_o),          32'd0);
    check({tag, "_memreq"},  32'(mem_req_valid_o), 32'd0);
    check({tag, "_memwe"},   32'(mem_req_we_o),    32'd0);
    check({tag, "_memaddr"}, mem_req_addr_o,       32'd0);
    check({tag, "_memwd"},   mem_req_wdata_o,      32'd0);
    check({tag, "_ifrsp"},   32'(if_rsp_valid_o),  32'd0);
    check({tag, "_ifdata"},  if_rsp_data_o,        32'd0);
    check({tag, "_dmrsp"},   32'(dm_rsp_valid_o),  32'd0);
    check({tag, "_dmdata"},  dm_rsp_data_o,        32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          if_act, dm_act, issued, done, wait_cnt, spur, busy_seen;
    logic [31:0] if_a, dm_a, dm_wd;
    logic        dm_w;
    bit          got;

    rst = 1'b1;
    if_req_valid_i = 1'b0; if_req_addr_i = '0;
    dm_req_valid_i = 1'b0; dm_req_we_i = 1'b0; dm_req_addr_i = '0; dm_req_wdata_i = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: single fetch, memory answers two cycles after REQ.
    mem_model[32'h40] = 32'hDEAD_BEEF;
    mem_lat = 2;
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h40;
    observe(12, 1'b0);
    check("t1_req_cnt",  32'(req_cnt),  32'd1);
    check("t1_req_we",   32'(req_we),   32'd0);
    check("t1_req_addr", req_addr,      32'h40);
    check("t1_busy",     32'(busy_cnt), 32'd4);
    check("t1_if_cnt",   32'(if_cnt),   32'd1);
    check("t1_if_at",    32'(if_at),    32'd4);
    check("t1_if_data",  if_data,       32'hDEAD_BEEF);
    check("t1_dm_cnt",   32'(dm_cnt),   32'd0);
    check_quiet("t1_after");

    // 2: store acked in the REQ cycle.
    mem_lat = 0;
    dm_req_valid_i = 1'b1; dm_req_we_i = 1'b1; dm_req_addr_i = 32'h10; dm_req_wdata_i = 32'h1234;
    observe(6, 1'b0);
    check("t2_req_cnt", 32'(req_cnt),  32'd1);
    check("t2_req_we",  32'(req_we),   32'd1);
    check("t2_req_addr", req_addr,     32'h10);
    check("t2_req_wd",  req_wdata,     32'h1234);
    check("t2_dm_cnt",  32'(dm_cnt),   32'd1);
    check("t2_dm_at",   32'(dm_at),    32'd2);
    check("t2_dm_data", dm_data,       32'd0);
    check("t2_busy",    32'(busy_cnt), 32'd2);
    check("t2_memwr",   mem_peek(32'h10), 32'h1234);
    dm_req_we_i = 1'b0;

    // 3: both stages valid from reset and held for three rounds.
    rst = 1'b1;
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h100;
    dm_req_valid_i = 1'b1; dm_req_we_i = 1'b0; dm_req_addr_i = 32'h200;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    observe(9, 1'b1);
    if_req_valid_i = 1'b0; dm_req_valid_i = 1'b0;
    check("t3_both", 32'(both_cnt), 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
    check("t3_order0", 32'(order[0]), 32'd1);
    check("t3_order1", 32'(order[1]), 32'd2);
    check("t3_order2", 32'(order[2]), 32'd1);
    check("t3_if_data", if_data, mem_default(32'h100));
`else
    check("t3_order0", 32'(order[0]), 32'd2);
    check("t3_order1", 32'(order[1]), 32'd2);
    check("t3_order2", 32'(order[2]), 32'd2);
    check("t3_if_cnt", 32'(if_cnt),   32'd0);
`endif
    check("t3_dm_data", dm_data, mem_default(32'h200));
    @(negedge clk);

    // 4: reset during WAIT; the late memory completion must be ignored.
    mem_lat = 2;
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h80;
    @(negedge clk);                       // REQ
    check("t4_req", 32'(mem_req_valid_o), 32'd1);
    @(negedge clk);                       // WAIT
    check("t4_wait_busy", 32'(busy_o), 32'd1);
    rst = 1'b1; if_req_valid_i = 1'b0;
    @(negedge clk);                       // memory answers now, DUT in reset IDLE
    rst = 1'b0;
    check("t4_late_rsp", 32'(mem_rsp_valid_i), 32'd1);
    check_quiet("t4_abort");
    spur = 0; busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_rsp_valid_o || dm_rsp_valid_o) spur++;
      if (busy_o) busy_seen++;
    end
    check("t4_no_rsp",  32'(spur),      32'd0);
    check("t4_no_busy", 32'(busy_seen), 32'd0);
    mem_lat = 1;
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h84;
    observe(8, 1'b0);
    check("t4_next_at",   32'(if_at), 32'd3);
    check("t4_next_data", if_data,    mem_default(32'h84));

    // 5: back-to-back fetch, new address presented in the IDLE cycle after the rsp.
    mem_lat = 0;
    if_req_valid_i = 1'b1; if_req_addr_i = 32'h40;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (if_rsp_valid_o) got = 1'b1;
    end
    check("t5_first_rsp", 32'(got), 32'd1);
    check("t5_first_data", if_rsp_data_o, 32'hDEAD_BEEF);
    if_req_addr_i = 32'h44;
    @(negedge clk);                       // IDLE, grant happens at the next edge
    check("t5_idle_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("t5_req_valid", 32'(mem_req_valid_o), 32'd1);
    check("t5_req_addr",  mem_req_addr_o, 32'h44);
    @(negedge clk);
    check("t5_rsp2_valid", 32'(if_rsp_valid_o), 32'd1);
    check("t5_rsp2_data",  if_rsp_data_o, mem_default(32'h44));
    if_req_valid_i = 1'b0;
    @(negedge clk);

    // 6: random traffic, random memory latency, scoreboard check.
    ref_mem = mem_model;
    mem_lat_rand = 1'b1;
    if_act = 0; dm_act = 0; issued = 0; done = 0;
    if_a = '0; dm_a = '0; dm_wd = '0; dm_w = 1'b0;
    wait_cnt = 0;
    while (wait_cnt < 3000 && (wait_cnt < 2400 || if_act != 0 || dm_act != 0)) begin
      @(negedge clk);
      wait_cnt++;
      check("r_one_rsp", 32'(if_rsp_valid_o & dm_rsp_valid_o), 32'd0);
      if (if_rsp_valid_o) begin
        check("r_if_expected", 32'(if_act), 32'd1);
        check("r_if_data", if_rsp_data_o, ref_read(if_a));
        if_act = 0; done++; if_req_valid_i = 1'b0;
      end
      if (dm_rsp_valid_o) begin
        check("r_dm_expected", 32'(dm_act), 32'd1);
        if (dm_w) begin
          check("r_st_data", dm_rsp_data_o, 32'd0);
          ref_mem[dm_a] = dm_wd;
        end else begin
          check("r_ld_data", dm_rsp_data_o, ref_read(dm_a));
        end
        dm_act = 0; done++; dm_req_valid_i = 1'b0;
      end
      if (wait_cnt < 2400) begin
        if (if_act == 0 && $urandom_range(0, 2) == 0) begin
          if_a = 32'($urandom_range(0, 15)) << 2;
          if_req_valid_i = 1'b1; if_req_addr_i = if_a;
          if_act = 1; issued++;
        end
        if (dm_act == 0 && $urandom_range(0, 2) == 0) begin
          dm_a  = 32'($urandom_range(0, 15)) << 2;
          dm_w  = 1'($urandom_range(0, 1));
          dm_wd = $urandom;
          dm_req_valid_i = 1'b1; dm_req_we_i = dm_w;
          dm_req_addr_i = dm_a; dm_req_wdata_i = dm_wd;
          dm_act = 1; issued++;
        end
      end
    end
    check("r_drained", 32'(if_act + dm_act), 32'd0);
    check("r_all_done", 32'(done), 32'(issued));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
